// File: rtl/alu32_arbiter_if.sv
// Bundles both requester channels, the ALU operand/result bus and the tagged
// response channel of alu32_arbiter.
interface alu32_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_sel;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_sel;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ovf;
  logic        rsp_err;

  logic        busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_err, busy
  );

  // Requesters, ALU and response consumer side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_err, busy
  );
endinterface

// File: rtl/alu32_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit ALU between two requesters,
// one transaction in flight, with a tagged valid/ready response channel.
module alu32_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu32_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        gnt_id;
  logic        accept;
  logic        sel_legal;
  logic [31:0] gnt_a;
  logic [31:0] gnt_b;
  logic [3:0]  gnt_sel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ready is masked by rst so reset wins over a same-cycle acceptance.
  always_comb begin
    state_nxt      = state;
    gnt_id         = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;
    bus.req0_ready = accept && !gnt_id;
    bus.req1_ready = accept && gnt_id;
    gnt_a          = gnt_id ? bus.req1_a   : bus.req0_a;
    gnt_b          = gnt_id ? bus.req1_b   : bus.req0_b;
    gnt_sel        = gnt_id ? bus.req1_sel : bus.req0_sel;
    sel_legal      = (gnt_sel[3:2] == 2'b00);
    bus.busy       = (state != IDLE);
    bus.rsp_valid  = (state == RESP);
    case (state)
      IDLE: if (accept) state_nxt = sel_legal ? EXEC : RESP;
      EXEC: if (cnt == CNT_LAST) state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      last_grant   <= 1'b1;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_sel  <= '0;
      bus.rsp_id   <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_ovf  <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= gnt_id;
            bus.rsp_id <= gnt_id;
            if (sel_legal) begin
              bus.alu_a   <= gnt_a;
              bus.alu_b   <= gnt_b;
              bus.alu_sel <= gnt_sel;
              cnt         <= '0;
            end else begin
              bus.rsp_data <= '0;
              bus.rsp_ovf  <= 1'b0;
              bus.rsp_err  <= 1'b1;
            end
          end
        end
        EXEC: cnt <= cnt + 4'd1;
        CAPT: begin
          bus.rsp_data <= bus.alu_out;
          bus.rsp_err  <= 1'b0;
          bus.rsp_ovf  <= (bus.alu_sel == 4'b0011) &&
                          (bus.alu_a[31] == bus.alu_b[31]) &&
                          (bus.alu_out[31] != bus.alu_a[31]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each fed by a behavioural registered ALU.
module tb_alu32_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu32_arbiter_if bus1 ();
  alu32_arbiter_if bus3 ();

  alu32_arbiter #(.ALU_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  alu32_arbiter #(.ALU_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] sel);
    case (sel)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a ^ b;
      4'b0011: return a + b;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] pipe1 [3];
  logic [31:0] pipe3 [3];
  always_ff @(posedge clk) begin
    pipe1[0] <= alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
    pipe3[0] <= alu_f(bus3.alu_a, bus3.alu_b, bus3.alu_sel);
    for (int i = 1; i < 3; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe3[i] <= pipe3[i-1];
    end
  end
  assign bus1.alu_out = pipe1[0];
  assign bus3.alu_out = pipe3[2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the ALU_LAT=1 instance; lat is cycles from acceptance to rsp_valid.
  task automatic run1(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] sel, input logic [31:0] exp_d,
                      input logic exp_ovf, input logic exp_err, input int lat);
    int   n;
    logic busy_ok;
    if (id) begin
      bus1.req1_valid = 1'b1; bus1.req1_a = a; bus1.req1_b = b; bus1.req1_sel = sel;
    end else begin
      bus1.req0_valid = 1'b1; bus1.req0_a = a; bus1.req0_b = b; bus1.req0_sel = sel;
    end
    #1;
    chk("ready_at_T", 32'(id ? bus1.req1_ready : bus1.req0_ready), 32'd1);
    step();
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    n = 1;
    busy_ok = bus1.busy;
    while (!bus1.rsp_valid && n < 20) begin
      step();
      n++;
      busy_ok = busy_ok & bus1.busy;
    end
    chk("rsp_latency", 32'(n), 32'(lat));
    chk("busy_in_flight", 32'(busy_ok), 32'd1);
    chk("rsp_data", bus1.rsp_data, exp_d);
    chk("rsp_ovf", 32'(bus1.rsp_ovf), 32'(exp_ovf));
    chk("rsp_err", 32'(bus1.rsp_err), 32'(exp_err));
    chk("rsp_id", 32'(bus1.rsp_id), 32'(id));
    step();
    chk("busy_after", 32'(bus1.busy), 32'd0);
  endtask

  initial begin
    int          n;
    logic        stable;
    logic [31:0] held;

    bus1.req0_valid = 0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_sel = '0;
    bus1.req1_valid = 0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_sel = '0;
    bus1.rsp_ready  = 1;
    bus3.req0_valid = 0; bus3.req0_a = '0; bus3.req0_b = '0; bus3.req0_sel = '0;
    bus3.req1_valid = 0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.req1_sel = '0;
    bus3.rsp_ready  = 0;

    step(); step();
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst_alu_a", bus1.alu_a, 32'h0);
    chk("rst_alu_sel", 32'(bus1.alu_sel), 32'd0);
    chk("rst_rsp_data", bus1.rsp_data, 32'h0);
    chk("rst_ready", 32'({bus1.req0_ready, bus1.req1_ready}), 32'd0);
    rst = 1'b0;
    step();

    // Single ADD, then overflow cases.
    run1(1'b0, 32'h0000_0005, 32'h0000_0003, 4'b0011, 32'h0000_0008, 1'b0, 1'b0, 3);
    run1(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 3);
    run1(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0011, 32'h8000_0000, 1'b1, 1'b0, 3);
    run1(1'b0, 32'h8000_0000, 32'h8000_0000, 4'b0011, 32'h0000_0000, 1'b1, 1'b0, 3);

    // Illegal opcode from req1: immediate error response, ALU select untouched.
    run1(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0111, 32'h0000_0000, 1'b0, 1'b1, 1);
    chk("illegal_alu_sel_kept", 32'(bus1.alu_sel), 32'd3);

    // Round-robin with both requesters continuously valid; last grant was req1.
    bus1.req0_valid = 1; bus1.req0_a = 32'hFFFF_0000; bus1.req0_b = 32'h0F0F_0F0F; bus1.req0_sel = 4'b0010;
    bus1.req1_valid = 1; bus1.req1_a = 32'h0000_0001; bus1.req1_b = 32'h0000_0002; bus1.req1_sel = 4'b0001;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(bus1.req0_ready || bus1.req1_ready) && n < 20) begin step(); n++; end
      chk("rr_grant", 32'({bus1.req1_ready, bus1.req0_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      n = 0;
      while (!bus1.rsp_valid && n < 20) begin step(); n++; end
      chk("rr_rsp_id", 32'(bus1.rsp_id), 32'(k % 2));
      chk("rr_rsp_data", bus1.rsp_data, (k % 2 == 0) ? 32'hF0F0_0F0F : 32'h0000_0003);
      chk("rr_no_ready_in_hs", 32'({bus1.req0_ready, bus1.req1_ready}), 32'd0);
      step();
    end
    bus1.req0_valid = 0;
    bus1.req1_valid = 0;
    step();

    // Reset in EXEC aborts the op; afterwards req0 wins the tie.
    bus1.req0_valid = 1; bus1.req0_a = 32'h1; bus1.req0_b = 32'h1; bus1.req0_sel = 4'b0011;
    step();
    bus1.req0_valid = 0;
    chk("abort_in_exec_busy", 32'(bus1.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(bus1.busy), 32'd0);
    chk("abort_alu_a", bus1.alu_a, 32'h0);
    stable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stable = stable | bus1.rsp_valid;
      step();
    end
    chk("abort_no_rsp", 32'(stable), 32'd0);
    bus1.req0_valid = 1; bus1.req0_a = 32'h0000_00F0; bus1.req0_b = 32'h0000_000F; bus1.req0_sel = 4'b0001;
    bus1.req1_valid = 1;
    #1;
    chk("post_rst_grant", 32'({bus1.req1_ready, bus1.req0_ready}), 32'd1);
    step();
    bus1.req0_valid = 0;
    bus1.req1_valid = 0;
    n = 0;
    while (!bus1.rsp_valid && n < 20) begin step(); n++; end
    chk("post_rst_data", bus1.rsp_data, 32'h0000_00FF);
    step();

    // ALU_LAT=3 with response backpressure.
    bus3.req0_valid = 1; bus3.req0_a = 32'h0000_0010; bus3.req0_b = 32'h0000_0020; bus3.req0_sel = 4'b0011;
    #1;
    chk("lat3_ready", 32'(bus3.req0_ready), 32'd1);
    step();
    bus3.req0_valid = 0;
    bus3.req1_valid = 1; bus3.req1_a = 32'h0000_0001; bus3.req1_b = 32'h0000_0002; bus3.req1_sel = 4'b0001;
    n = 1;
    while (!bus3.rsp_valid && n < 20) begin step(); n++; end
    chk("lat3_latency", 32'(n), 32'd5);
    chk("lat3_data", bus3.rsp_data, 32'h0000_0030);
    held   = bus3.rsp_data;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      stable = stable & bus3.rsp_valid & (bus3.rsp_data == held) & !bus3.rsp_id &
               !bus3.rsp_err & !bus3.req0_ready & !bus3.req1_ready;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    bus3.rsp_ready = 1;
    #1;
    chk("bp_hs_no_ready", 32'(bus3.req1_ready), 32'd0);
    step();
    chk("bp_next_ready", 32'(bus3.req1_ready), 32'd1);
    step();
    bus3.req1_valid = 0;
    n = 1;
    while (!bus3.rsp_valid && n < 20) begin step(); n++; end
    chk("lat3_req1_latency", 32'(n), 32'd5);
    chk("lat3_req1_id", 32'(bus3.rsp_id), 32'd1);
    chk("lat3_req1_data", bus3.rsp_data, 32'h0000_0003);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
